dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shares the single-port data RAM between two requesters: port 0 (core data port) and port 1 (loader/debug port). Each port has a valid/ready request channel and a one-cycle-latency response channel. Arbitration is round-robin and allows at most one RAM access per cycle. The block sits between the requesters and the RAM, translates byte addresses into RAM word addresses, and drives the RAM read/write select.

## Interface
Parameters:
- DATA_W, 32, data word width
- ADDR_W, 32, requester byte-address width
- MEM_AW, 10, RAM word-address width (RAM word address = byte address[MEM_AW+1:2])

Ports:
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- req_valid  in  2  per-port request valid (bit 0 = core, bit 1 = loader)
- req_we  in  2  per-port write enable (1 = write, 0 = read)
- req_addr0, req_addr1  in  ADDR_W  per-port byte address
- req_wdata0, req_wdata1  in  DATA_W  per-port write data
- req_ready  out  2  per-port request accepted this cycle
- rsp_valid  out  2  per-port response valid (one-cycle pulse)
- rsp_err  out  1  response is an address fault (qualified by rsp_valid)
- rsp_rdata  out  DATA_W  read data (shared by both ports, qualified by rsp_valid)
- mem_addr  out  MEM_AW  RAM word address
- mem_wdata  out  DATA_W  RAM write data
- mem_rw  out  1  RAM select: 1 = read, 0 = write
- mem_rdata  in  DATA_W  RAM registered read data, valid one cycle after address

## Operation
- Handshake: a request transfers when req_valid[i] && req_ready[i]. req_ready is combinational from req_valid and the round-robin pointer. At most one bit of req_ready is set per cycle.
- Arbitration:
  - If one port is valid, that port is granted.
  - If both are valid, the port not granted most recently is granted.
  - The pointer `last` updates only on a grant.
  - After reset `last` = 1, so port 0 wins the first contention.
- Address check: the request faults if byte address[1:0] != 0 or address bits above MEM_AW+1 are nonzero.
  - A faulting request is still accepted (req_ready = 1).
  - No RAM access occurs: mem_rw stays 1.
  - The response carries rsp_err = 1 and rsp_rdata = 0.
- Granted read: mem_addr = addr[MEM_AW+1:2], mem_rw = 1.
- Granted write: mem_addr as for a read, mem_wdata = wdata, mem_rw = 0.
- Idle cycles: mem_rw = 1, mem_addr holds its previous value, mem_wdata = 0. The RAM is never written without a granted write.
- Response pipeline: a one-stage register holds {valid, port, is_read, err}.
  - Next cycle, rsp_valid[port] = 1.
  - Reads return rsp_rdata = mem_rdata.
  - Writes return an acknowledge with rsp_rdata = 0.
  - Responses cannot be back-pressured. Requesters must accept them.
- Back-to-back accesses: a new grant can be issued every cycle, including read-after-write to the same address. The RAM resolves ordering, and the read returns the newly written data.

## Timing
- Reset values: req_ready = 0 while RESET = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_rw = 1, mem_addr = 0, mem_wdata = 0, `last` = 1, response stage empty.
- Latency: acceptance in cycle N gives rsp_valid in cycle N+1. Sustained throughput is one access per cycle.
- RESET asserted with a response pending: the response is dropped and rsp_valid = 0 in the following cycle.
- A request that is valid during RESET is not accepted. It is arbitrated normally from the first cycle after deassertion.
- mem_addr, mem_wdata and mem_rw are combinational from the grant in the same cycle, because the RAM captures them on the next edge.

## Structure
- Package dmem_arb_pkg holds:
  - constants MEM_AW and DATA_W
  - port enum {PORT_CORE = 0, PORT_LDR = 1}
  - RAM select constants MEM_READ = 1'b1, MEM_WRITE = 1'b0
  - packed struct rsp_stage_t {valid, port, is_read, err}
- Sub-module rr_arbiter2 contains the two-input round-robin grant and the `last` pointer register. The top level contains the address check, RAM muxing and the response stage.

## Test plan
- Reset then single read: core reads 0x0000_0010 holding 0xDEADBEEF → mem_addr = 4 and mem_rw = 1 in cycle N; rsp_valid = 2'b01 and rsp_rdata = 0xDEADBEEF in cycle N+1.
- Contention: both ports valid for 4 cycles → grants alternate core, ldr, core, ldr. Each rsp_valid follows its grant by one cycle.
- Write then read: ldr writes 0x1234_5678 to 0x0000_0FFC, core reads the same address next cycle → mem_addr = 0x3FF. The read response is 0x1234_5678.
- Faults: core read at 0x0000_0002, then ldr write at 0x0000_1000 → both accepted, mem_rw stays 1, rsp_err = 1 and rsp_rdata = 0 for each, and the RAM contents are unchanged.
- Reset mid-operation: accept a read, assert RESET the next cycle → rsp_valid stays 0, req_ready = 0 during reset, and the first contention after reset is granted to core.
- Idle: no req_valid for 10 cycles → mem_rw = 1 and rsp_valid = 0 throughout.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// No logic; consumed by the arbiter top and the requester interface users.
// RAM select encoding and the response-stage record live here.
package dmem_arb_pkg;

    localparam int DATA_W = 32;
    localparam int MEM_AW = 10;

    typedef enum logic {
        PORT_CORE = 1'b0,
        PORT_LDR  = 1'b1
    } port_e;

    localparam logic MEM_READ  = 1'b1;
    localparam logic MEM_WRITE = 1'b0;

    typedef struct packed {
        logic  valid;
        port_e port;
        logic  is_read;
        logic  err;
    } rsp_stage_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-port requester bundle: valid/ready request channel plus response channel.
// Response arrives one cycle after acceptance.
// Responses cannot be stalled; only the request side has back-pressure (req_ready).
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_we;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        req_ready;
    logic [1:0]        rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/dmem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant with a registered "last granted" pointer.
// Grant is combinational from req and the pointer (zero latency).
// No grants while rst is high; the pointer moves only when a grant is issued.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_q;
    logic last_d;

    // Pick the single requester, or the one not served most recently on contention.
    always_comb begin
        gnt    = 2'b00;
        last_d = last_q;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        if (gnt[0]) begin
            last_d = 1'b0;
        end else if (gnt[1]) begin
            last_d = 1'b1;
        end
    end

    // Pointer starts at port 1 so the core wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core and loader request ports.
// RAM controls are combinational from the grant; response one cycle after accept.
// Request side back-pressured by round-robin req_ready; responses cannot stall.
module dmem_arbiter #(
    parameter int DATA_W = dmem_arb_pkg::DATA_W,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = dmem_arb_pkg::MEM_AW
) (
    input  logic              CLK,
    input  logic              RESET,
    dmem_arbiter_if.slave     bus,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata
);
    import dmem_arb_pkg::*;

    logic [1:0]        gnt;
    port_e             sel;
    logic              granted;
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic              fault;
    logic              access;
    logic [MEM_AW-1:0] mem_addr_q;
    logic [MEM_AW-1:0] mem_addr_d;
    rsp_stage_t        rsp_q;
    rsp_stage_t        rsp_d;
    logic              rsp_live;

    rr_arbiter2 u_arb (
        .clk (CLK),
        .rst (RESET),
        .req (bus.req_valid),
        .gnt (gnt)
    );

    assign bus.req_ready = gnt;

    // Mux the granted port onto the RAM; faulting requests are accepted but never touch the RAM.
    always_comb begin
        granted = |gnt;
        sel     = gnt[1] ? PORT_LDR : PORT_CORE;
        addr    = (sel == PORT_LDR) ? bus.req_addr1  : bus.req_addr0;
        wdata   = (sel == PORT_LDR) ? bus.req_wdata1 : bus.req_wdata0;
        we      = (sel == PORT_LDR) ? bus.req_we[1]  : bus.req_we[0];
        fault   = (addr[1:0] != 2'b00) || (addr[ADDR_W-1:MEM_AW+2] != '0);
        access  = granted && !fault;

        if (RESET) begin
            mem_addr_d = '0;
        end else if (access) begin
            mem_addr_d = addr[MEM_AW+1:2];
        end else begin
            mem_addr_d = mem_addr_q;
        end

        mem_addr  = mem_addr_d;
        mem_rw    = (access && we) ? MEM_WRITE : MEM_READ;
        mem_wdata = (access && we) ? wdata : '0;

        rsp_d         = '0;
        rsp_d.valid   = granted;
        rsp_d.port    = sel;
        rsp_d.is_read = !we;
        rsp_d.err     = fault;
    end

    // Hold the last RAM address across idle cycles and stage the response record.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            mem_addr_q <= '0;
            rsp_q      <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            rsp_q      <= rsp_d;
        end
    end

    // Drive the response; a pending response is suppressed while reset is asserted.
    always_comb begin
        rsp_live      = rsp_q.valid && !RESET;
        bus.rsp_valid = 2'b00;
        if (rsp_live) begin
            bus.rsp_valid = (rsp_q.port == PORT_LDR) ? 2'b10 : 2'b01;
        end
        bus.rsp_err   = rsp_live && rsp_q.err;
        bus.rsp_rdata = (rsp_live && rsp_q.is_read && !rsp_q.err) ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic [31:0] mem_rdata;
    logic [31:0] ram [0:1023];

    int total;
    int bad;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .MEM_AW(10)) dut (
        .CLK       (clk),
        .RESET     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port RAM with registered read data.
    always @(posedge clk) begin
        if (mem_rw == 1'b0) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  e_rdy;
        logic        e_rw;
        logic [9:0]  e_addr;
        logic [31:0] e_wd;
        logic [1:0]  e_rspv;
        logic        e_err;
        logic [31:0] e_rd;
    } vec_t;

    localparam int NV = 20;
    vec_t vt [NV];

    function automatic vec_t mk(logic rst, logic [1:0] vld, logic [1:0] we,
                                logic [31:0] a0, logic [31:0] a1,
                                logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] e_rdy, logic e_rw, logic [9:0] e_addr,
                                logic [31:0] e_wd, logic [1:0] e_rspv,
                                logic e_err, logic [31:0] e_rd);
        vec_t v;
        v.rst = rst; v.vld = vld; v.we = we; v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.e_rdy = e_rdy; v.e_rw = e_rw; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_rspv = e_rspv; v.e_err = e_err; v.e_rd = e_rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        reset          = v.rst;
        bus.req_valid  = v.vld;
        bus.req_we     = v.we;
        bus.req_addr0  = v.a0;
        bus.req_addr1  = v.a1;
        bus.req_wdata0 = v.d0;
        bus.req_wdata1 = v.d1;
    endtask

    task automatic go_idle();
        reset          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_we     = 2'b00;
        bus.req_addr0  = '0;
        bus.req_addr1  = '0;
        bus.req_wdata0 = '0;
        bus.req_wdata1 = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[0] = 32'hA5A5_A5A5;
        ram[4] = 32'hDEAD_BEEF;
        ram[5] = 32'h1111_1111;
        ram[6] = 32'h2222_2222;
        mem_rdata = 32'h0;

        //          rst vld    we     a0           a1           d0  d1            rdy    rw    addr     wd            rspv   err   rd
        vt[0]  = mk(1, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h0,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[1]  = mk(1, 2'b01, 2'b00, 32'h10,      32'h0,       0,  0,            2'b00, 1'b1, 10'h0,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[2]  = mk(0, 2'b01, 2'b00, 32'h10,      32'h0,       0,  0,            2'b01, 1'b1, 10'h4,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[3]  = mk(0, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h4,   32'h0,        2'b01, 1'b0, 32'hDEAD_BEEF);
        vt[4]  = mk(0, 2'b10, 2'b00, 32'h0,       32'h18,      0,  0,            2'b10, 1'b1, 10'h6,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[5]  = mk(0, 2'b11, 2'b00, 32'h14,      32'h18,      0,  0,            2'b01, 1'b1, 10'h5,   32'h0,        2'b10, 1'b0, 32'h2222_2222);
        vt[6]  = mk(0, 2'b11, 2'b00, 32'h14,      32'h18,      0,  0,            2'b10, 1'b1, 10'h6,   32'h0,        2'b01, 1'b0, 32'h1111_1111);
        vt[7]  = mk(0, 2'b11, 2'b00, 32'h14,      32'h18,      0,  0,            2'b01, 1'b1, 10'h5,   32'h0,        2'b10, 1'b0, 32'h2222_2222);
        vt[8]  = mk(0, 2'b11, 2'b00, 32'h14,      32'h18,      0,  0,            2'b10, 1'b1, 10'h6,   32'h0,        2'b01, 1'b0, 32'h1111_1111);
        vt[9]  = mk(0, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h6,   32'h0,        2'b10, 1'b0, 32'h2222_2222);
        vt[10] = mk(0, 2'b10, 2'b10, 32'h0,       32'hFFC,     0,  32'h1234_5678, 2'b10, 1'b0, 10'h3FF, 32'h1234_5678, 2'b00, 1'b0, 32'h0);
        vt[11] = mk(0, 2'b01, 2'b00, 32'hFFC,     32'h0,       0,  0,            2'b01, 1'b1, 10'h3FF, 32'h0,        2'b10, 1'b0, 32'h0);
        vt[12] = mk(0, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h3FF, 32'h0,        2'b01, 1'b0, 32'h1234_5678);
        vt[13] = mk(0, 2'b01, 2'b00, 32'h2,       32'h0,       0,  0,            2'b01, 1'b1, 10'h3FF, 32'h0,        2'b00, 1'b0, 32'h0);
        vt[14] = mk(0, 2'b10, 2'b10, 32'h0,       32'h1000,    0,  32'hCAFE_F00D, 2'b10, 1'b1, 10'h3FF, 32'h0,        2'b01, 1'b1, 32'h0);
        vt[15] = mk(0, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h3FF, 32'h0,        2'b10, 1'b1, 32'h0);
        vt[16] = mk(0, 2'b01, 2'b00, 32'h10,      32'h0,       0,  0,            2'b01, 1'b1, 10'h4,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[17] = mk(1, 2'b11, 2'b00, 32'h10,      32'h18,      0,  0,            2'b00, 1'b1, 10'h0,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[18] = mk(0, 2'b11, 2'b00, 32'h10,      32'h18,      0,  0,            2'b01, 1'b1, 10'h4,   32'h0,        2'b00, 1'b0, 32'h0);
        vt[19] = mk(0, 2'b00, 2'b00, 32'h0,       32'h0,       0,  0,            2'b00, 1'b1, 10'h4,   32'h0,        2'b01, 1'b0, 32'hDEAD_BEEF);

        apply(vt[0]);
        @(posedge clk);
        #1;

        // One vector per cycle: inputs driven after the edge, outputs sampled on the falling edge.
        for (int i = 0; i < NV; i++) begin
            apply(vt[i]);
            @(negedge clk);
            chk($sformatf("v%0d req_ready", i), {30'h0, bus.req_ready}, {30'h0, vt[i].e_rdy});
            chk($sformatf("v%0d mem_rw", i),    {31'h0, mem_rw},        {31'h0, vt[i].e_rw});
            chk($sformatf("v%0d mem_addr", i),  {22'h0, mem_addr},      {22'h0, vt[i].e_addr});
            chk($sformatf("v%0d mem_wdata", i), mem_wdata,              vt[i].e_wd);
            chk($sformatf("v%0d rsp_valid", i), {30'h0, bus.rsp_valid}, {30'h0, vt[i].e_rspv});
            chk($sformatf("v%0d rsp_err", i),   {31'h0, bus.rsp_err},   {31'h0, vt[i].e_err});
            chk($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata,          vt[i].e_rd);
            @(posedge clk);
            #1;
        end

        // Ten idle cycles: RAM stays in read mode, nothing is granted or answered.
        go_idle();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("idle%0d mem_rw", i),    {31'h0, mem_rw},        32'h1);
            chk($sformatf("idle%0d rsp_valid", i), {30'h0, bus.rsp_valid}, 32'h0);
            chk($sformatf("idle%0d req_ready", i), {30'h0, bus.req_ready}, 32'h0);
            chk($sformatf("idle%0d mem_wdata", i), mem_wdata,              32'h0);
            @(posedge clk);
            #1;
        end

        // RAM contents: the faulting write must not have landed, the legal one must have.
        chk("ram word0 untouched", ram[0],      32'hA5A5_A5A5);
        chk("ram word3ff written", ram[10'h3FF], 32'h1234_5678);
        chk("ram word4 untouched", ram[4],      32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
